// File: rtl/gray_code_pkg.sv
// Shared types and Gray/binary conversion helpers for the Gray-code arithmetic datapath.
// Conversions work on a MAX_WIDTH vector; leading zeros do not change either mapping.
package gray_code_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MAX_WIDTH     = 32;
  localparam int unsigned NUM_STAGES    = 3;

  typedef enum logic [1:0] {
    StageConv = 2'd0,
    StageSub  = 2'd1,
    StageOut  = 2'd2
  } stage_e;

  function automatic logic [MAX_WIDTH-1:0] gray2bin_f(input logic [MAX_WIDTH-1:0] gray);
    logic [MAX_WIDTH-1:0] bin;
    bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] bin2gray_f(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray converter.
module bin2gray
  import gray_code_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray_f(MAX_WIDTH'(bin)));

endmodule

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter.
module gray2bin
  import gray_code_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin_f(MAX_WIDTH'(gray)));

endmodule

// File: rtl/gray_pipe_stage.sv
// Payload-plus-valid register slice; loads from upstream when its load input is high.
module gray_pipe_stage #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             in_valid,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  output logic [Width-1:0] out_data
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  // Payload only captures real beats so bubbles leave the last result in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/gray_code_subtractor_pipe.sv
// Three-stage valid/ready pipelined Gray-code subtractor: diff = a - b - bi, with borrow-out.
module gray_code_subtractor_pipe
  import gray_code_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bo
);

  localparam int unsigned ConvW = 2 * WIDTH + 1;
  localparam int unsigned SubW  = WIDTH + 1;

  logic [NUM_STAGES-1:0] valid;
  logic [NUM_STAGES-1:0] load;

  logic [WIDTH-1:0] a_bin, b_bin, diff_gray;
  logic [ConvW-1:0] conv_d, conv_q;
  logic [SubW-1:0]  sub_d, sub_q;
  logic [SubW-1:0]  out_d, out_q;
  logic [WIDTH-1:0] conv_a, conv_b;
  logic             conv_bi;

  // A stage loads when it is empty or its own content moves on this cycle.
  always_comb begin
    load            = '0;
    load[StageOut]  = !valid[StageOut] || out_ready;
    load[StageSub]  = !valid[StageSub] || load[StageOut];
    load[StageConv] = !valid[StageConv] || load[StageSub];
  end

  assign in_ready = load[StageConv];

  gray2bin #(.WIDTH(WIDTH)) u_a_g2b (.gray(a), .bin(a_bin));
  gray2bin #(.WIDTH(WIDTH)) u_b_g2b (.gray(b), .bin(b_bin));

  assign conv_d = {a_bin, b_bin, bi};

  gray_pipe_stage #(.Width(ConvW)) u_stage_conv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load[StageConv]),
    .in_valid (in_valid),
    .in_data  (conv_d),
    .out_valid(valid[StageConv]),
    .out_data (conv_q)
  );

  assign {conv_a, conv_b, conv_bi} = conv_q;
  // MSB of the widened difference is the borrow-out.
  assign sub_d = {1'b0, conv_a} - {1'b0, conv_b} - {{WIDTH{1'b0}}, conv_bi};

  gray_pipe_stage #(.Width(SubW)) u_stage_sub (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load[StageSub]),
    .in_valid (valid[StageConv]),
    .in_data  (sub_d),
    .out_valid(valid[StageSub]),
    .out_data (sub_q)
  );

  bin2gray #(.WIDTH(WIDTH)) u_diff_b2g (.bin(sub_q[WIDTH-1:0]), .gray(diff_gray));

  assign out_d = {sub_q[WIDTH], diff_gray};

  gray_pipe_stage #(.Width(SubW)) u_stage_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load[StageOut]),
    .in_valid (valid[StageSub]),
    .in_data  (out_d),
    .out_valid(valid[StageOut]),
    .out_data (out_q)
  );

  assign {bo, diff} = out_q;
  assign out_valid  = valid[StageOut];

endmodule

// File: tb/tb_gray_code_subtractor_pipe.sv
// Bench for gray_code_subtractor_pipe: vector table, streaming, backpressure, random, reset.
module tb_gray_code_subtractor_pipe;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bi = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         bo;

  always #5 clk = ~clk;

  gray_code_subtractor_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bi       (bi),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bo       (bo)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] diff;
    logic         bo;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bo;
  } res_t;

  vec_t   vecs[7];
  res_t   exp_cur;
  res_t   exp_q[$];
  int     out_cyc_q[$];
  int     n_cmp = 0;
  int     n_fail = 0;
  int     n_out = 0;
  int     cyc = 0;
  logic   hold_prev = 1'b0;
  logic [W-1:0] prev_diff;
  logic   prev_bo;
  logic   stop_toggle = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  function automatic res_t model(input logic [W-1:0] ga, input logic [W-1:0] gb, input logic c);
    int           r;
    logic [W-1:0] d;
    res_t         m;
    r = int'(g2b(ga)) - int'(g2b(gb)) - (c ? 1 : 0);
    d = r[W-1:0];
    m.bo = (r < 0);
    m.diff = d ^ (d >> 1);
    return m;
  endfunction

  // Scoreboard monitor: pop on delivery, push on acceptance, watch stalled outputs.
  always @(negedge clk) begin : monitor
    res_t e;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_diff", diff, prev_diff);
        check("stall_bo", bo, prev_bo);
      end
      if (out_valid && out_ready) begin
        n_out++;
        out_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got diff=%b bo=%b, expected no beat", diff, bo);
        end else begin
          e = exp_q.pop_front();
          check("diff", diff, e.diff);
          check("bo", bo, e.bo);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(exp_cur);
      hold_prev = out_valid && !out_ready;
      prev_diff = diff;
      prev_bo   = bo;
    end
  end

  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input res_t e);
    a = ta;
    b = tb;
    bi = tc;
    exp_cur = e;
    in_valid = 1'b1;
  endtask

  // Returns on the posedge+1 after the beat was taken.
  task automatic send_beat(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                           input res_t e, output int waited);
    waited = 0;
    drive(ta, tb, tc, e);
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) fail_now("accept_timeout");
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_random(output int waited);
    logic [W-1:0] ra, rb;
    logic         rc;
    ra = W'($urandom);
    rb = W'($urandom);
    rc = 1'($urandom);
    send_beat(ra, rb, rc, model(ra, rb, rc), waited);
  endtask

  // Single beat into an empty pipe; out_valid must be seen in the third cycle after the handshake.
  task automatic timed_beat(input vec_t v);
    res_t e;
    int   waited;
    int   lat;
    e.diff = v.diff;
    e.bo   = v.bo;
    out_ready = 1'b1;
    send_beat(v.a, v.b, v.bi, e, waited);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, 3);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int waited;
    int stalls;
    int acc;
    int base_n;
    int base_c;

    vecs[0] = '{a: 4'b0111, b: 4'b0010, bi: 1'b0, diff: 4'b0011, bo: 1'b0};
    vecs[1] = '{a: 4'b0010, b: 4'b0111, bi: 1'b0, diff: 4'b1001, bo: 1'b1};
    vecs[2] = '{a: 4'b0000, b: 4'b0000, bi: 1'b1, diff: 4'b1000, bo: 1'b1};
    vecs[3] = '{a: 4'b1000, b: 4'b0000, bi: 1'b1, diff: 4'b1001, bo: 1'b0};
    vecs[4] = '{a: 4'b1000, b: 4'b1000, bi: 1'b0, diff: 4'b0000, bo: 1'b0};
    vecs[5] = '{a: 4'b0001, b: 4'b0001, bi: 1'b1, diff: 4'b1000, bo: 1'b1};
    vecs[6] = '{a: 4'b1100, b: 4'b0110, bi: 1'b1, diff: 4'b0010, bo: 1'b0};

    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bo", bo, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) timed_beat(vecs[i]);

    // Streaming: 32 back-to-back beats, out_ready held high.
    base_n = n_out;
    base_c = out_cyc_q.size();
    stalls = 0;
    for (int i = 0; i < 32; i++) begin
      send_random(waited);
      stalls += waited;
    end
    repeat (6) @(posedge clk);
    #1;
    check("stream_stalls", stalls, 0);
    check("stream_count", n_out - base_n, 32);
    if (out_cyc_q.size() >= base_c + 32)
      check("stream_span", out_cyc_q[base_c+31] - out_cyc_q[base_c], 31);
    else
      fail_now("stream_span");
    check("stream_drained", exp_q.size(), 0);

    // Backpressure: consumer stalled for 6 cycles with beats offered every cycle.
    out_ready = 1'b0;
    acc = 0;
    drive(W'($urandom), 4'b0101, 1'b0, '0);
    exp_cur = model(a, b, bi);
    for (int c = 0; c < 6; c++) begin
      logic hs;
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        acc++;
        a = W'($urandom);
        b = W'($urandom);
        bi = 1'($urandom);
        exp_cur = model(a, b, bi);
      end
    end
    check("bp_accepts", acc, 3);
    check("bp_in_ready", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("bp_drained", exp_q.size(), 0);

    // Random valid/ready toggling over 1000 beats.
    base_n = n_out;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_random(waited);
        end
        stop_toggle = 1'b1;
      end
      begin
        while (!stop_toggle) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("rand_drained", exp_q.size(), 0);
    check("rand_count", n_out - base_n, 1000);

    // Reset with three beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_beat(vecs[i].a, vecs[i].b, vecs[i].bi, model(vecs[i].a, vecs[i].b, vecs[i].bi),
                waited);
    end
    check("pre_rst_out_valid", out_valid, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    drive(vecs[3].a, vecs[3].b, vecs[3].bi, model(vecs[3].a, vecs[3].b, vecs[3].bi));
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_diff", diff, 0);
    check("mid_rst_bo", bo, 0);
    check("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    base_n = n_out;
    repeat (6) @(posedge clk);
    #1;
    check("no_stale", n_out - base_n, 0);
    timed_beat(vecs[6]);
    check("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
